tm_engine: RTL and testbench

- Parametrised, runtime-programmable Turing-machine engine; successor to the fixed-table busy-beaver block.
- Transition table is loaded through a rule-write port instead of being compiled in.
- Symbol width, state count, tape address width and step counter width are parameters; the tape lives in external DRAM behind the simm_16mb handshake.
- Adds tape clear on demand, a step limit, abort, and write-skip when the symbol is unchanged; the step count drives the max7219 display in the top level.

---
 rtl/tm_engine_if.sv | 23 ++
 rtl/tm_engine.sv | 181 ++++++++++++++++++
 tb/tb_tm_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_engine_if.sv
// Tape memory handshake between tm_engine and the DRAM controller.
// The engine drives the request side; the controller answers with ack/busy/data.
interface tm_engine_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] m_addr;
    logic              m_write;
    logic              m_ena;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic              m_busy;
    logic              m_ack;

    modport master (
        output m_addr, m_write, m_ena, wr_data,
        input  rd_data, m_busy, m_ack
    );

    modport slave (
        input  m_addr, m_write, m_ena, wr_data,
        output rd_data, m_busy, m_ack
    );
endinterface

// File: rtl/tm_engine.sv
// Runtime-programmable Turing-machine engine with a DRAM-backed tape.
// Rules are loaded through a write port; tape accesses use a req/ack/busy handshake.
module tm_engine #(
    parameter int SYM_W   = 3,
    parameter int STATE_W = 2,
    parameter int ADDR_W  = 24,
    parameter int COUNT_W = 40,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1) << (ADDR_W - 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear_tape,
    input  logic                     abort,
    input  logic [COUNT_W-1:0]       max_steps,
    input  logic                     rule_we,
    input  logic [STATE_W+SYM_W-1:0] rule_idx,
    input  logic [STATE_W+SYM_W:0]   rule_data,
    tm_engine_if.master              mem,
    output logic [COUNT_W-1:0]       count,
    output logic [STATE_W-1:0]       cur_state,
    output logic [ADDR_W-1:0]        head,
    output logic                     running,
    output logic                     done,
    output logic                     halted,
    output logic                     limit_hit
);
    localparam int IDX_W  = STATE_W + SYM_W;
    localparam int RULE_W = STATE_W + 1 + SYM_W;
    localparam logic [STATE_W-1:0] HALT = '1;
    localparam logic [RULE_W-1:0] RULE_RST = {HALT, 1'b0, {SYM_W{1'b0}}};

    typedef enum logic [3:0] {
        IDLE, CLR_REQ, CLR_WAIT, RD_REQ, RD_WAIT,
        EXEC, WR_REQ, WR_WAIT, MOVE, DONE
    } state_t;

    state_t              st;
    logic [RULE_W-1:0]   rules [2**IDX_W];
    logic [COUNT_W-1:0]  max_q;
    logic [SYM_W-1:0]    sym;
    logic [SYM_W-1:0]    new_sym;
    logic [STATE_W-1:0]  nxt_state;
    logic                dir;
    logic [RULE_W-1:0]   rule;
    logic [ADDR_W-1:0]   nxt_head;
    logic                idle;

    assign idle     = (st == IDLE) || (st == DONE);
    assign rule     = rules[{cur_state, sym}];
    assign nxt_head = dir ? head + ADDR_W'(1) : head - ADDR_W'(1);

    generate
        if (SYM_W < 8) begin : g_unused
            logic unused_rd;
            assign unused_rd = ^mem.rd_data[7:SYM_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) rules[i] <= RULE_RST;
        end else if (rule_we && idle) begin
            rules[rule_idx] <= rule_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            count       <= '0;
            cur_state   <= '0;
            head        <= START_ADDR;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            limit_hit   <= 1'b0;
            max_q       <= '0;
            sym         <= '0;
            new_sym     <= '0;
            nxt_state   <= '0;
            dir         <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_write <= 1'b0;
            mem.m_ena   <= 1'b0;
            mem.wr_data <= '0;
        end else begin
            unique case (st)
                IDLE, DONE: begin
                    if (start) begin
                        count       <= '0;
                        cur_state   <= '0;
                        head        <= START_ADDR;
                        halted      <= 1'b0;
                        limit_hit   <= 1'b0;
                        done        <= 1'b0;
                        running     <= 1'b1;
                        max_q       <= max_steps;
                        mem.m_ena   <= 1'b1;
                        mem.m_write <= clear_tape;
                        mem.wr_data <= '0;
                        mem.m_addr  <= clear_tape ? '0 : START_ADDR;
                        st          <= clear_tape ? CLR_REQ : RD_REQ;
                    end
                end
                CLR_REQ: if (mem.m_ack) begin
                    mem.m_ena <= 1'b0;
                    st        <= CLR_WAIT;
                end
                // m_addr doubles as the clear sweep pointer
                CLR_WAIT: if (!mem.m_busy) begin
                    if (abort) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                        st      <= DONE;
                    end else if (mem.m_addr == '1) begin
                        mem.m_addr  <= head;
                        mem.m_write <= 1'b0;
                        mem.m_ena   <= 1'b1;
                        st          <= RD_REQ;
                    end else begin
                        mem.m_addr <= mem.m_addr + ADDR_W'(1);
                        mem.m_ena  <= 1'b1;
                        st         <= CLR_REQ;
                    end
                end
                RD_REQ: if (mem.m_ack) begin
                    mem.m_ena <= 1'b0;
                    st        <= RD_WAIT;
                end
                RD_WAIT: if (!mem.m_busy) begin
                    sym <= mem.rd_data[SYM_W-1:0];
                    st  <= EXEC;
                end
                EXEC: begin
                    {nxt_state, dir, new_sym} <= rule;
                    if (count != '1) count <= count + COUNT_W'(1);
                    if (rule[SYM_W-1:0] == sym) begin
                        st <= MOVE;
                    end else begin
                        mem.m_addr  <= head;
                        mem.m_write <= 1'b1;
                        mem.wr_data <= 8'(rule[SYM_W-1:0]);
                        mem.m_ena   <= 1'b1;
                        st          <= WR_REQ;
                    end
                end
                WR_REQ: if (mem.m_ack) begin
                    mem.m_ena <= 1'b0;
                    st        <= WR_WAIT;
                end
                WR_WAIT: if (!mem.m_busy) st <= MOVE;
                MOVE: begin
                    head      <= nxt_head;
                    cur_state <= nxt_state;
                    if (nxt_state == HALT) begin
                        halted  <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b1;
                        st      <= DONE;
                    end else if (max_q != '0 && count == max_q) begin
                        limit_hit <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        st        <= DONE;
                    end else if (abort) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                        st      <= DONE;
                    end else begin
                        mem.m_addr  <= nxt_head;
                        mem.m_write <= 1'b0;
                        mem.m_ena   <= 1'b1;
                        st          <= RD_REQ;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tm_engine.sv
// Randomized bench for tm_engine: DRAM models with ack delay and busy stretch,
// plus a tape-level Turing-machine reference model.
module tb_tm_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, clear_tape = 1'b0, abort = 1'b0, rule_we = 1'b0;
    logic        w_start = 1'b0, w_rule_we = 1'b0;
    logic [39:0] max_steps = '0;
    logic [4:0]  rule_idx = '0;
    logic [5:0]  rule_data = '0;
    logic [39:0] count, w_count;
    logic [1:0]  cur_state, w_state;
    logic [7:0]  head;
    logic [3:0]  w_head;
    logic running, done, halted, limit_hit;
    logic w_running, w_done, w_halted, w_limit;

    tm_engine_if #(.ADDR_W(8)) bus ();
    tm_engine_if #(.ADDR_W(4)) wbus ();

    tm_engine #(
        .SYM_W(3), .STATE_W(2), .ADDR_W(8), .COUNT_W(40), .START_ADDR(8'd128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear_tape(clear_tape),
        .abort(abort), .max_steps(max_steps), .rule_we(rule_we),
        .rule_idx(rule_idx), .rule_data(rule_data), .mem(bus),
        .count(count), .cur_state(cur_state), .head(head),
        .running(running), .done(done), .halted(halted), .limit_hit(limit_hit)
    );

    tm_engine #(
        .SYM_W(3), .STATE_W(2), .ADDR_W(4), .COUNT_W(40), .START_ADDR(4'd15)
    ) wdut (
        .clk(clk), .rst(rst), .start(w_start), .clear_tape(clear_tape),
        .abort(abort), .max_steps(max_steps), .rule_we(w_rule_we),
        .rule_idx(rule_idx), .rule_data(rule_data), .mem(wbus),
        .count(w_count), .cur_state(w_state), .head(w_head),
        .running(w_running), .done(w_done), .halted(w_halted), .limit_hit(w_limit)
    );

    // Main DRAM model: programmable ack delay, random busy after each ack
    logic [7:0] mem [256];
    int ack_delay = 0, busy_max = 0, wc = 0, busy_left = 0;
    int rd_cnt = 0, wr_cnt = 0, viol = 0;
    logic pe = 1'b0, pa = 1'b0, pw = 1'b0;
    logic [7:0] pad = '0;

    assign bus.m_ack   = bus.m_ena && (wc >= ack_delay);
    assign bus.m_busy  = (busy_left != 0);
    assign bus.rd_data = mem[bus.m_addr];

    always @(posedge clk) begin
        if (rst) begin
            wc <= 0; busy_left <= 0; pe <= 1'b0; pa <= 1'b0;
        end else begin
            if (pe && !pa && (!bus.m_ena || bus.m_addr != pad || bus.m_write != pw))
                viol <= viol + 1;
            pe <= bus.m_ena; pa <= bus.m_ack; pad <= bus.m_addr; pw <= bus.m_write;
            if (bus.m_ena && bus.m_ack) begin
                wc <= 0;
                busy_left <= int'($urandom_range(busy_max, 0));
                if (bus.m_write) begin
                    mem[bus.m_addr] <= bus.wr_data;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end else begin
                if (bus.m_ena) wc <= wc + 1;
                if (busy_left != 0) busy_left <= busy_left - 1;
            end
        end
    end

    logic [7:0] wmem [16];
    assign wbus.m_ack   = wbus.m_ena;
    assign wbus.m_busy  = 1'b0;
    assign wbus.rd_data = wmem[wbus.m_addr];
    always @(posedge clk)
        if (wbus.m_ena && wbus.m_write) wmem[wbus.m_addr] <= wbus.wr_data;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [5:0] rules_m [32];
    logic [7:0] ref_tape [256];

    task automatic put_rule(input int idx, input int data);
        @(negedge clk);
        rule_idx = 5'(idx); rule_data = 6'(data); rule_we = 1'b1;
        @(negedge clk);
        rule_we = 1'b0;
        rules_m[idx] = 6'(data);
    endtask

    task automatic run(input bit clr, input int maxs);
        @(negedge clk);
        clear_tape = clr; max_steps = 40'(maxs); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        chk("done", done, 1);
    endtask

    // Tape-level reference: one loop iteration per machine step
    task automatic model_run(input bit clr, input int maxs, output int cnt, output int hd,
                             output int st, output bit hlt, output bit lim, output int wr);
        int sym, r, nsym;
        cnt = 0; hd = 128; st = 0; hlt = 0; lim = 0; wr = 0;
        if (clr) for (int i = 0; i < 256; i++) ref_tape[i] = 8'h00;
        while (!hlt && !lim && cnt < 10000) begin
            sym = int'(ref_tape[hd]) % 8;
            r = int'(rules_m[st * 8 + sym]);
            nsym = r % 8;
            cnt++;
            if (nsym != sym) begin ref_tape[hd] = 8'(nsym); wr++; end
            hd = ((r / 8) % 2 == 1) ? (hd + 1) % 256 : (hd + 255) % 256;
            st = r / 16;
            if (st == 3) hlt = 1;
            else if (maxs != 0 && cnt == maxs) lim = 1;
        end
    endtask

    task automatic check_run(input bit clr, input int maxs, input int budget);
        int e_cnt, e_head, e_st, e_wr, w0, r0, bad;
        bit e_h, e_l;
        for (int i = 0; i < 256; i++) ref_tape[i] = mem[i];
        w0 = wr_cnt; r0 = rd_cnt;
        model_run(clr, maxs, e_cnt, e_head, e_st, e_h, e_l, e_wr);
        run(clr, maxs);
        wait_done(budget);
        chk("count", count, e_cnt);
        chk("head", head, e_head);
        chk("state", cur_state, e_st);
        chk("halted", halted, e_h);
        chk("limit", limit_hit, e_l);
        chk("writes", wr_cnt - w0, e_wr + (clr ? 256 : 0));
        chk("reads", rd_cnt - r0, e_cnt);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_tape[i]) bad++;
        chk("tape", bad, 0);
    endtask

    initial begin
        int ones, found, w0, r0;
        longint c0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) wmem[i] = 8'h00;
        for (int i = 0; i < 32; i++) rules_m[i] = 6'h30;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_head", head, 128);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_ena", bus.m_ena, 0);

        // BB(2) from a dirty tape with clear
        put_rule(0, 'h19); put_rule(1, 'h11); put_rule(8, 'h01); put_rule(9, 'h39);
        check_run(1'b1, 0, 20000);
        ones = 0;
        for (int i = 0; i < 256; i++) if (mem[i] == 8'd1) ones++;
        chk("bb_count", count, 6);
        chk("bb_ones", ones, 4);
        chk("bb_state", cur_state, 3);
        chk("bb_halted", halted, 1);

        check_run(1'b1, 4, 20000);
        chk("lim_count", count, 4);
        chk("lim_flag", limit_hit, 1);
        check_run(1'b1, 0, 20000);
        chk("rerun_count", count, 6);

        // Write-skip: 0RA over a zero tape
        put_rule(0, 'h08);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        w0 = wr_cnt; r0 = rd_cnt;
        check_run(1'b0, 5, 2000);
        chk("skip_writes", wr_cnt - w0, 0);
        chk("skip_reads", rd_cnt - r0, 5);
        chk("skip_head", head, 133);

        // Wrap on the 4-bit instance
        @(negedge clk);
        rule_idx = 5'd0; rule_data = 6'h39; w_rule_we = 1'b1; max_steps = '0;
        @(negedge clk);
        w_rule_we = 1'b0; w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int n = 0; n < 100 && !w_done; n++) @(negedge clk);
        chk("wrap_done", w_done, 1);
        chk("wrap_head", w_head, 0);
        chk("wrap_byte", wmem[15], 1);
        chk("wrap_count", w_count, 1);
        chk("wrap_halted", w_halted, 1);

        // Abort during a slow read, with a dropped rule write
        for (int i = 0; i < 8; i++) put_rule(i, 'h09);
        ack_delay = 7;
        run(1'b0, 0);
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            @(negedge clk);
            if (count >= 2 && bus.m_ena && !bus.m_write) found = 1;
        end
        chk("abort_rd_seen", found, 1);
        abort = 1'b1; c0 = longint'(count);
        rule_idx = 5'd0; rule_data = 6'h39; rule_we = 1'b1;
        @(negedge clk);
        rule_we = 1'b0;
        wait_done(500);
        chk("abort_steps", (longint'(count) - c0) <= 1, 1);
        chk("abort_halted", halted, 0);
        chk("abort_limit", limit_hit, 0);
        chk("hs_viol", viol, 0);
        abort = 1'b0; ack_delay = 0;
        check_run(1'b0, 3, 500);

        // Reset while a write request is pending
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ack_delay = 5;
        run(1'b0, 0);
        found = 0;
        for (int n = 0; n < 500 && found == 0; n++) begin
            @(negedge clk);
            if (bus.m_ena && bus.m_write) found = 1;
        end
        chk("wr_req_seen", found, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ena", bus.m_ena, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_running", running, 0);
        @(negedge clk);
        rst = 1'b0; ack_delay = 0;
        for (int i = 0; i < 32; i++) rules_m[i] = 6'h30;
        check_run(1'b0, 0, 500);
        chk("post_rst_count", count, 1);

        // Random tables, limits, latencies and tapes
        busy_max = 3;
        for (int t = 0; t < 20; t++) begin
            ack_delay = int'($urandom_range(2, 0));
            for (int i = 0; i < 32; i++) put_rule(i, int'($urandom_range(63, 0)));
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            check_run(1'($urandom_range(1, 0)), int'($urandom_range(40, 1)), 20000);
        end
        chk("hs_viol_end", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
